// File: rtl/peripheral_spi.sv
// SPI master (mode 0, MSB first, 8-bit) on the J1 I/O bus.
// The SCK half-period is DIV+1 system clocks; a write to TXDATA starts one byte transfer.
module peripheral_spi #(
    parameter logic [7:0] DIV_RST = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  div_r;
    logic [7:0]  cnt_r;
    logic [3:0]  half_r;
    logic [7:0]  tx_sh_r;
    logic [7:0]  rx_sh_r;
    logic [7:0]  rx_data_r;
    logic        sck_r;
    logic        mosi_r;
    logic        ss_n_r;
    logic        done_r;

    logic        wr_en_s;
    logic        rd_en_s;
    logic        busy_s;
    logic        half_done_s;
    logic        start_s;
    logic        finish_s;
    logic        unused_bits_s;

    assign wr_en_s       = cs & wr;
    assign rd_en_s       = cs & rd;
    assign busy_s        = (state_r != IDLE);
    assign half_done_s   = (cnt_r == div_r);
    assign start_s       = wr_en_s && (addr == 4'h2) && !busy_s;
    assign unused_bits_s = &{1'b0, d_in[15:8], tx_sh_r[7]};

    assign spi_sck  = sck_r;
    assign spi_mosi = mosi_r;
    assign spi_ss_n = ss_n_r;

    // Next-state logic; finish_s marks the HOLD->IDLE completion edge.
    always_comb begin
        state_s  = state_r;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (half_done_s) begin
                    state_s = XFER;
                end else begin
                    state_s = SETUP;
                end
            end
            XFER: begin
                // 16 half-periods: 8 high, 8 low; the last low half ends XFER.
                if (half_done_s && (half_r == 4'd15)) begin
                    state_s = HOLD;
                end else begin
                    state_s = XFER;
                end
            end
            HOLD: begin
                if (half_done_s) begin
                    state_s  = IDLE;
                    finish_s = 1'b1;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Half-period timer, restarted at every half-period boundary and held in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 8'd0;
        end else if ((state_r == IDLE) || half_done_s) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // Shift datapath, SPI pins, divider and receive register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r     <= DIV_RST;
            half_r    <= 4'd0;
            tx_sh_r   <= 8'd0;
            rx_sh_r   <= 8'd0;
            rx_data_r <= 8'd0;
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
            ss_n_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        tx_sh_r <= d_in[7:0];
                        mosi_r  <= d_in[7];
                        ss_n_r  <= 1'b0;
                        rx_sh_r <= 8'd0;
                        half_r  <= 4'd0;
                    end
                    if (wr_en_s && (addr == 4'h0)) begin
                        div_r <= d_in[7:0];
                    end
                end
                SETUP: begin
                    if (half_done_s) begin
                        sck_r   <= 1'b1;
                        rx_sh_r <= {rx_sh_r[6:0], spi_miso};
                        half_r  <= 4'd0;
                    end
                end
                XFER: begin
                    if (half_done_s && (half_r != 4'd15)) begin
                        half_r <= half_r + 4'd1;
                        if (!half_r[0]) begin
                            sck_r <= 1'b0;
                            // The 8th falling edge leaves the last bit on MOSI.
                            if (half_r != 4'd14) begin
                                tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                                mosi_r  <= tx_sh_r[6];
                            end
                        end else begin
                            sck_r   <= 1'b1;
                            rx_sh_r <= {rx_sh_r[6:0], spi_miso};
                        end
                    end
                end
                HOLD: begin
                    if (half_done_s) begin
                        ss_n_r    <= 1'b1;
                        mosi_r    <= 1'b0;
                        rx_data_r <= rx_sh_r;
                    end
                end
                default: begin
                    sck_r  <= 1'b0;
                    mosi_r <= 1'b0;
                    ss_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Done flag: completion wins over a simultaneous RXDATA read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r <= 1'b0;
        end else if (finish_s) begin
            done_r <= 1'b1;
        end else if (start_s || (rd_en_s && (addr == 4'h4))) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_r;
        end
    end

    // Read mux.
    always_comb begin
        d_out = 16'h0000;
        if (cs) begin
            case (addr)
                4'h0:    d_out = {8'h00, div_r};
                4'h4:    d_out = {8'h00, rx_data_r};
                4'h6:    d_out = {14'd0, done_r, busy_s};
                default: d_out = 16'h0000;
            endcase
        end else begin
            d_out = 16'h0000;
        end
    end

endmodule

// File: tb/tb_peripheral_spi.sv
// Directed self-checking bench for peripheral_spi: register map, timing, loopback and reset abort.
module tb_peripheral_spi;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_ss_n;

    logic        loop_en;
    logic        miso_val;
    logic [7:0]  cap;
    int          cap_n;
    int          ss_cnt;
    int          hi_cnt;
    int          tests_run;
    int          failed;
    logic [15:0] rdata;
    int          n;

    peripheral_spi #(.DIV_RST(8'd4)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .cs       (cs),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .d_out    (d_out),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss_n (spi_ss_n)
    );

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture MOSI on every SCK rising edge.
    always @(posedge spi_sck) begin
        cap   = {cap[6:0], spi_mosi};
        cap_n = cap_n + 1;
    end

    // Count clk cycles with slave selected and with SCK high.
    always @(posedge clk) begin
        if (!spi_ss_n) ss_cnt = ss_cnt + 1;
        if (spi_sck) hi_cnt = hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            failed = failed + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = d_out;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 4'h0;
    endtask

    task automatic clear_counts();
        cap = 8'h00; cap_n = 0; ss_cnt = 0; hi_cnt = 0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!spi_ss_n && k < 2000) begin
            @(negedge clk);
            k = k + 1;
        end
        check(tag, {15'd0, spi_ss_n}, 16'h0001);
    endtask

    initial begin
        tests_run = 0; failed = 0;
        rst = 1'b0; d_in = 16'h0000; cs = 1'b0; addr = 4'h0; rd = 1'b0; wr = 1'b0;
        loop_en = 1'b0; miso_val = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_pins", {13'd0, spi_ss_n, spi_sck, spi_mosi}, 16'h0004);
        rst = 1'b1;

        // Reset values and register map corners
        rd_reg(4'h6, rdata); check("rst_status", rdata, 16'h0000);
        rd_reg(4'h0, rdata); check("rst_div", rdata, 16'h0004);
        rd_reg(4'h8, rdata); check("unmapped_rd", rdata, 16'h0000);
        wr_reg(4'h6, 16'hFFFF);
        rd_reg(4'h6, rdata); check("status_wr_ignored", rdata, 16'h0000);
        wr_reg(4'h0, 16'h12AB);
        @(negedge clk); cs = 1'b0; addr = 4'h0; #1 check("cs_low_rd", d_out, 16'h0000);
        rd_reg(4'h0, rdata); check("div_rw", rdata, 16'h00AB);

        // DIV=0, A5 looped back
        wr_reg(4'h0, 16'h0000);
        loop_en = 1'b1;
        clear_counts();
        wr_reg(4'h2, 16'h00A5);
        check("busy_after_start", {14'd0, d_out[1:0]}, 16'h0000);
        rd_reg(4'h6, rdata); check("status_busy", rdata, 16'h0001);
        wait_idle("a5_timeout");
        check("a5_mosi", {8'h00, cap}, 16'h00A5);
        check("a5_pulses", cap_n[15:0], 16'd8);
        check("a5_ss_cycles", ss_cnt[15:0], 16'd18);
        check("a5_mosi_idle", {15'd0, spi_mosi}, 16'h0000);
        rd_reg(4'h6, rdata); check("a5_status", rdata, 16'h0002);
        rd_reg(4'h4, rdata); check("a5_rxdata", rdata, 16'h00A5);
        rd_reg(4'h6, rdata); check("a5_done_clr", rdata, 16'h0000);

        // DIV=3, 3C with MISO held high
        wr_reg(4'h0, 16'h0003);
        loop_en = 1'b0; miso_val = 1'b1;
        clear_counts();
        wr_reg(4'h2, 16'h003C);
        n = 0;
        while (!spi_sck && n < 100) begin @(negedge clk); n = n + 1; end
        n = 0;
        while (spi_sck && n < 100) begin @(negedge clk); n = n + 1; end
        check("3c_sck_high", n[15:0], 16'd4);
        n = 0;
        while (!spi_sck && n < 100) begin @(negedge clk); n = n + 1; end
        check("3c_sck_low", n[15:0], 16'd4);
        wait_idle("3c_timeout");
        check("3c_mosi", {8'h00, cap}, 16'h003C);
        check("3c_hi_cycles", hi_cnt[15:0], 16'd32);
        check("3c_ss_cycles", ss_cnt[15:0], 16'd72);
        rd_reg(4'h6, rdata); check("3c_status", rdata, 16'h0002);
        rd_reg(4'h4, rdata); check("3c_rxdata", rdata, 16'h00FF);
        rd_reg(4'h6, rdata); check("3c_done_clr", rdata, 16'h0000);

        // Writes while busy are ignored
        wr_reg(4'h0, 16'h0000);
        loop_en = 1'b1; miso_val = 1'b0;
        clear_counts();
        wr_reg(4'h2, 16'h00F0);
        repeat (3) @(negedge clk);
        wr_reg(4'h2, 16'h0011);
        wr_reg(4'h0, 16'h0007);
        wait_idle("f0_timeout");
        repeat (20) @(negedge clk);
        check("f0_no_restart", {15'd0, spi_ss_n}, 16'h0001);
        check("f0_mosi", {8'h00, cap}, 16'h00F0);
        check("f0_pulses", cap_n[15:0], 16'd8);
        check("f0_ss_cycles", ss_cnt[15:0], 16'd18);
        rd_reg(4'h0, rdata); check("f0_div_kept", rdata, 16'h0000);
        rd_reg(4'h4, rdata); check("f0_rxdata", rdata, 16'h00F0);

        // Reset mid-transfer after the 3rd SCK pulse
        wr_reg(4'h0, 16'h0003);
        clear_counts();
        wr_reg(4'h2, 16'h0096);
        n = 0;
        while (!(cap_n == 3 && !spi_sck) && n < 500) begin @(negedge clk); n = n + 1; end
        check("abort_reach", {15'd0, (n < 500)}, 16'h0001);
        #2 rst = 1'b0;
        #1 check("abort_pins", {13'd0, spi_ss_n, spi_sck, spi_mosi}, 16'h0004);
        @(negedge clk);
        rst = 1'b1;
        rd_reg(4'h6, rdata); check("abort_status", rdata, 16'h0000);
        rd_reg(4'h4, rdata); check("abort_rxdata", rdata, 16'h0000);
        rd_reg(4'h0, rdata); check("abort_div", rdata, 16'h0004);

        // RXDATA read on the completion edge
        wr_reg(4'h0, 16'h0000);
        loop_en = 1'b1;
        clear_counts();
        wr_reg(4'h2, 16'h005A);
        repeat (17) @(negedge clk);
        check("race_pre_ss", {15'd0, spi_ss_n}, 16'h0000);
        cs = 1'b1; rd = 1'b1; addr = 4'h4;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 4'h0;
        check("race_post_ss", {15'd0, spi_ss_n}, 16'h0001);
        rd_reg(4'h6, rdata); check("race_status", rdata, 16'h0002);
        rd_reg(4'h4, rdata); check("race_rxdata", rdata, 16'h005A);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
